// File: rtl/gigatron_pkg.sv
// Shared constants and types for the Gigatron input scheduler.
// IN_IDLE is the "no buttons pressed" byte seen by the core.
package gigatron_pkg;

    localparam logic [7:0] IN_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } sched_state_t;

endpackage

// File: rtl/in_fifo.sv
// Synchronous host byte FIFO with registered occupancy count.
// Read data is first-word-fall-through from the head entry.
module in_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_data,
    input  logic       i_rd_en,
    output logic [7:0] o_rd_data,
    output logic       o_full,
    output logic       o_empty
);

    import gigatron_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign push      = i_wr_en & ~o_full;
    assign pop       = i_rd_en & ~o_empty;
    assign o_full    = (count == CW'(DEPTH));
    assign o_empty   = (count == '0);
    assign o_rd_data = mem[rd_ptr];

    // Storage array write; contents are don't-care until pushed
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_sched.sv
// Frame-paced input scheduler: injects host bytes into the core's
// input port, or passes synced pad state. Feature macro: INPUT_SCHED_FIFO_EN.
module input_sched #(
    parameter int HOLD_FRAMES = 2,
    parameter int GAP_FRAMES  = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_vsync,
    input  logic [7:0] i_buttons,
    input  logic [7:0] i_host_data,
    input  logic       i_host_valid,
    output logic       o_host_ready,
    output logic [7:0] o_in,
    output logic       o_injecting
);

    import gigatron_pkg::*;

    logic [7:0] btn_s1;
    logic [7:0] btn_s2;
    logic       vsync_d;
    logic       frame_edge;

    // Pad synchronizer and vsync delay for falling-edge detect
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_s1  <= IN_IDLE;
            btn_s2  <= IN_IDLE;
            vsync_d <= 1'b1;
        end else begin
            btn_s1  <= i_buttons;
            btn_s2  <= btn_s1;
            vsync_d <= i_vsync;
        end
    end

    assign frame_edge = vsync_d & ~i_vsync;

`ifdef INPUT_SCHED_FIFO_EN

    localparam logic [7:0] HOLD_CNT = 8'(HOLD_FRAMES);
    localparam logic [7:0] GAP_CNT  = 8'(GAP_FRAMES);

    sched_state_t state_q;
    sched_state_t state_d;
    logic [7:0]   cnt_q;
    logic [7:0]   cnt_d;
    logic [7:0]   in_d;
    logic         dispatch;
    logic         fifo_pop;
    logic [7:0]   fifo_rd_data;
    logic         fifo_full;
    logic         fifo_empty;

    in_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wr_en   (i_host_valid),
        .i_wr_data (i_host_data),
        .i_rd_en   (fifo_pop),
        .o_rd_data (fifo_rd_data),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    // State, frame counter and presented byte
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            o_in    <= IN_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_in    <= in_d;
        end
    end

    // Next state: everything advances only on a frame edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_d     = o_in;
        dispatch = 1'b0;
        fifo_pop = 1'b0;
        if (frame_edge) begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q > 8'd1) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (GAP_FRAMES != 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_CNT;
                        in_d    = IN_IDLE;
                    end else begin
                        dispatch = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q > 8'd1) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        dispatch = 1'b1;
                    end
                end
                default: dispatch = 1'b1;
            endcase
            if (dispatch) begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    in_d     = fifo_rd_data;
                    cnt_d    = HOLD_CNT;
                    state_d  = ST_HOLD;
                end else begin
                    in_d    = btn_s2;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // Status outputs from registered state and count
    always_comb begin
        o_injecting  = (state_q != ST_IDLE);
        o_host_ready = ~fifo_full;
    end

`else

    localparam int unused_cfg = HOLD_FRAMES + GAP_FRAMES + FIFO_DEPTH;

    logic unused_host;

    assign unused_host  = ^{i_host_data, i_host_valid};
    assign o_host_ready = 1'b0;
    assign o_injecting  = 1'b0;

    // Plain pad passthrough, refreshed once per frame
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_in <= IN_IDLE;
        end else if (frame_edge) begin
            o_in <= btn_s2;
        end
    end

`endif

endmodule
